// File: rtl/threshold_calibrator.sv
// rtl/threshold_calibrator.sv - windowed ADC min/max tracker that publishes a mid-point threshold and hysteresis
module threshold_calibrator #(
  parameter int ADC_WIDTH      = 12,
  parameter int WINDOW_LOG2    = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int HYST_MIN       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic [ADC_WIDTH-1:0] adc_value,
  input  logic                 adc_value_change,
  output logic [ADC_WIDTH-1:0] threshold,
  output logic [ADC_WIDTH-3:0] hysteresis,
  output logic [ADC_WIDTH-1:0] win_min,
  output logic [ADC_WIDTH-1:0] win_max,
  output logic                 cal_valid,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int W  = ADC_WIDTH;
  localparam int HW = ADC_WIDTH - 2;
  localparam int CW = WINDOW_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_PUBLISH = 2'd3;

  localparam logic [CW-1:0] N_LAST   = {1'b0, {WINDOW_LOG2{1'b1}}};
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0]  THR_RST  = {1'b1, {(W-1){1'b0}}};
  localparam logic [HW-1:0] HYST_RST = HW'(HYST_MIN);

  logic [1:0]    state;
  logic          change_q;
  logic          sample_event;
  logic [W-1:0]  run_min;
  logic [W-1:0]  run_max;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic [W-1:0]  thr_r;
  logic [HW-1:0] hyst_r;
  logic [W-1:0]  span;

  // The copy also tracks the input during reset, so release never looks like a toggle.
  always_ff @(posedge clk) begin
    change_q <= adc_value_change;
  end

  assign sample_event = (adc_value_change != change_q);
  assign busy         = (state != S_IDLE);
  assign span         = run_max - run_min;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      threshold   <= THR_RST;
      hysteresis  <= HYST_RST;
      win_min     <= '0;
      win_max     <= '1;
      cal_valid   <= 1'b0;
      timeout_err <= 1'b0;
      run_min     <= '1;
      run_max     <= '0;
      count       <= '0;
      timer       <= '0;
      thr_r       <= '0;
      hyst_r      <= '0;
    end else begin
      cal_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((start || continuous) && !abort) begin
            state       <= S_ACQUIRE;
            run_min     <= '1;
            run_max     <= '0;
            count       <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_ACQUIRE: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (sample_event) begin
            if (adc_value < run_min) run_min <= adc_value;
            if (adc_value > run_max) run_max <= adc_value;
            count <= count + 1'b1;
            timer <= '0;
            if (count == N_LAST) state <= S_COMPUTE;
          end else if (timer == T_LAST) begin
            state       <= S_IDLE;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_COMPUTE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            // Sum is formed one bit wider than the samples so the mid-point never wraps.
            thr_r <= W'(({1'b0, run_max} + {1'b0, run_min}) >> 1);
            if (int'(span) < 4 * HYST_MIN) hyst_r <= HYST_RST;
            else                           hyst_r <= HW'(span >> 2);
            state <= S_PUBLISH;
          end
        end
        S_PUBLISH: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            threshold  <= thr_r;
            hysteresis <= hyst_r;
            win_min    <= run_min;
            win_max    <= run_max;
            cal_valid  <= 1'b1;
            if (continuous) begin
              state   <= S_ACQUIRE;
              run_min <= '1;
              run_max <= '0;
              count   <= '0;
              timer   <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_threshold_calibrator.sv
// tb/tb_threshold_calibrator.sv - randomized self-checking bench for threshold_calibrator
module tb_threshold_calibrator;

  localparam int W  = 12;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  adc_value = '0;
  logic          adc_value_change = 1'b0;
  logic [W-1:0]  threshold;
  logic [W-3:0]  hysteresis;
  logic [W-1:0]  win_min;
  logic [W-1:0]  win_max;
  logic          cal_valid;
  logic          busy;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  int samp[4];
  int exp_thr  = 2048;
  int exp_hyst = 8;
  int exp_min  = 0;
  int exp_max  = 4095;

  threshold_calibrator #(
    .ADC_WIDTH(W), .WINDOW_LOG2(2), .TIMEOUT_CYCLES(TO), .HYST_MIN(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .adc_value(adc_value), .adc_value_change(adc_value_change),
    .threshold(threshold), .hysteresis(hysteresis), .win_min(win_min), .win_max(win_max),
    .cal_valid(cal_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    adc_value        = W'(v);
    adc_value_change = ~adc_value_change;
    tick();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs the four samples in samp[] and checks the publish timing and values.
  task automatic do_window(input bit use_start, input string tag);
    int mn, mx, span, thr, hyst;
    if (use_start) pulse_start();
    mn = 4095; mx = 0;
    foreach (samp[i]) begin
      if (samp[i] < mn) mn = samp[i];
      if (samp[i] > mx) mx = samp[i];
    end
    thr  = (mn + mx) / 2;
    span = mx - mn;
    hyst = (span < 4 * 8) ? 8 : span / 4;
    foreach (samp[i]) send(samp[i]);
    total++;
    if ({cal_valid, busy} !== 2'b01) begin
      bad++;
      $display("FAIL %s_t0 cal_valid/busy got=%b want=01", tag, {cal_valid, busy});
    end
    tick();
    total++;
    if ({cal_valid, busy} !== 2'b01) begin
      bad++;
      $display("FAIL %s_t1 cal_valid/busy got=%b want=01", tag, {cal_valid, busy});
    end
    tick();
    total++;
    if ({cal_valid, threshold, hysteresis, win_min, win_max} !==
        {1'b1, W'(thr), 10'(hyst), W'(mn), W'(mx)}) begin
      bad++;
      $display("FAIL %s_pub got v=%b thr=%0d hyst=%0d min=%0d max=%0d want v=1 thr=%0d hyst=%0d min=%0d max=%0d",
               tag, cal_valid, threshold, hysteresis, win_min, win_max, thr, hyst, mn, mx);
    end
    exp_thr = thr; exp_hyst = hyst; exp_min = mn; exp_max = mx;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    adc_value_change = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({threshold, hysteresis, win_min, win_max, cal_valid, busy, timeout_err} !==
        {12'd2048, 10'd8, 12'd0, 12'hFFF, 3'b000}) begin
      bad++;
      $display("FAIL reset_vals got thr=%0d hyst=%0d min=%0d max=%0d v=%b busy=%b to=%b",
               threshold, hysteresis, win_min, win_max, cal_valid, busy, timeout_err);
    end
    tick();
    total++;
    if ({cal_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle cal_valid/busy got=%b want=00", {cal_valid, busy});
    end
  endtask

  task automatic test_timeout;
    int waited;
    bit saw_valid;
    pulse_start();
    send(10); send(20); send(30);
    waited = 0;
    saw_valid = 0;
    while (busy && waited < 3 * TO) begin
      tick();
      waited++;
      if (cal_valid) saw_valid = 1;
    end
    total++;
    if (busy !== 1'b0 || waited < TO - 1 || waited > TO + 1) begin
      bad++;
      $display("FAIL timeout_time busy=%b waited=%0d want busy=0 waited~%0d", busy, waited, TO);
    end
    total++;
    if ({timeout_err, saw_valid, threshold} !== {1'b1, 1'b0, 12'd2048}) begin
      bad++;
      $display("FAIL timeout_state got to=%b v=%b thr=%0d want to=1 v=0 thr=2048",
               timeout_err, saw_valid, threshold);
    end
    pulse_start();
    total++;
    if ({timeout_err, busy} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_clear got to/busy=%b want=01", {timeout_err, busy});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_abort busy got=%b want=0", busy);
    end
  endtask

  task automatic test_directed;
    samp = '{100, 300, 200, 250};
    do_window(1, "dir_a");
    total++;
    if ({threshold, hysteresis, win_min, win_max} !== {12'd200, 10'd50, 12'd100, 12'd300}) begin
      bad++;
      $display("FAIL dir_a_const got thr=%0d hyst=%0d want thr=200 hyst=50", threshold, hysteresis);
    end
    tick();
    samp = '{500, 505, 510, 502};
    do_window(1, "dir_b");
    total++;
    if ({threshold, hysteresis} !== {12'd505, 10'd8}) begin
      bad++;
      $display("FAIL dir_b_const got thr=%0d hyst=%0d want thr=505 hyst=8", threshold, hysteresis);
    end
    tick();
    samp = '{0, 4095, 4095, 0};
    do_window(1, "dir_extreme");
    tick();
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      int base;
      base = $urandom_range(0, 4000);
      foreach (samp[i])
        samp[i] = (k % 2 == 1) ? base + $urandom_range(0, 60) : $urandom_range(0, 4095);
      do_window(1, "rand");
      tick();
      total++;
      if ({cal_valid, busy} !== 2'b00) begin
        bad++;
        $display("FAIL rand_after cal_valid/busy got=%b want=00", {cal_valid, busy});
      end
    end
  endtask

  task automatic test_continuous;
    continuous = 1'b1;
    tick();
    samp = '{0, 4095, 2000, 1000};
    do_window(0, "cont_1");
    continuous = 1'b0;
    samp = '{1000 + $urandom_range(0, 50), 1100, 1050, 1000};
    do_window(0, "cont_2");
    tick();
    total++;
    if ({cal_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL cont_end cal_valid/busy got=%b want=00", {cal_valid, busy});
    end
  endtask

  task automatic test_abort;
    pulse_start();
    send(700); send(900); send(800); send(750);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({cal_valid, busy, threshold, hysteresis, win_min, win_max} !==
        {2'b00, W'(exp_thr), 10'(exp_hyst), W'(exp_min), W'(exp_max)}) begin
      bad++;
      $display("FAIL abort_compute got v=%b busy=%b thr=%0d want v=0 busy=0 thr=%0d",
               cal_valid, busy, threshold, exp_thr);
    end
    tick();
    total++;
    if (cal_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_compute_late cal_valid got=%b want=0", cal_valid);
    end
    pulse_start();
    send(1); send(2); send(3); send(4);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({cal_valid, busy, threshold, win_min, win_max} !==
        {2'b00, W'(exp_thr), W'(exp_min), W'(exp_max)}) begin
      bad++;
      $display("FAIL abort_publish got v=%b busy=%b thr=%0d want v=0 busy=0 thr=%0d",
               cal_valid, busy, threshold, exp_thr);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle busy got=%b want=0", busy);
    end
  endtask

  task automatic test_start_ignored;
    pulse_start();
    send(3000); send(3100);
    pulse_start();
    samp = '{3000, 3100, 3050, 2990};
    send(3050);
    send(2990);
    total++;
    if ({cal_valid, busy} !== 2'b01) begin
      bad++;
      $display("FAIL start_ign_t0 cal_valid/busy got=%b want=01", {cal_valid, busy});
    end
    tick(); tick();
    total++;
    if ({cal_valid, threshold, hysteresis, win_min, win_max} !==
        {1'b1, 12'd3045, 10'd27, 12'd2990, 12'd3100}) begin
      bad++;
      $display("FAIL start_ign_pub got v=%b thr=%0d hyst=%0d min=%0d max=%0d want v=1 thr=3045 hyst=27 min=2990 max=3100",
               cal_valid, threshold, hysteresis, win_min, win_max);
    end
    exp_thr = 3045; exp_hyst = 27; exp_min = 2990; exp_max = 3100;
    tick();
  endtask

  task automatic test_rst_mid;
    pulse_start();
    send(111); send(222);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({cal_valid, busy, threshold, hysteresis, win_min, win_max} !==
        {2'b00, 12'd2048, 10'd8, 12'd0, 12'hFFF}) begin
      bad++;
      $display("FAIL rst_mid got v=%b busy=%b thr=%0d hyst=%0d min=%0d max=%0d",
               cal_valid, busy, threshold, hysteresis, win_min, win_max);
    end
    send(333);
    total++;
    if ({cal_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL rst_mid_after cal_valid/busy got=%b want=00", {cal_valid, busy});
    end
    samp = '{400, 404, 402, 401};
    do_window(1, "rst_recover");
    tick();
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_directed();
    test_random();
    test_continuous();
    test_abort();
    test_start_ignored();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/threshold_calibrator.md
THRESHOLD_CALIBRATOR -- requirements
Module: threshold_calibrator

Interface
REQ-001 SHALL provide parameter ADC_WIDTH, default 12, meaning ADC sample width in bits (W below).
REQ-002 SHALL provide parameter WINDOW_LOG2, default 8, meaning log2 of samples per calibration window (N = 2^WINDOW_LOG2).
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum number of clk cycles allowed between sample events.
REQ-004 SHALL provide parameter HYST_MIN, default 8, meaning the hysteresis floor; it must fit in W-2 bits.
REQ-005 SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-006 Ports, as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request to run one calibration window
- continuous  in  1  level; re-arm automatically after each publish
- abort  in  1  level; cancel the window in progress
- adc_value  in  W  current ADC sample
- adc_value_change  in  1  toggles once per new sample
- threshold  out  W  published threshold
- hysteresis  out  W-2  published hysteresis
- win_min, win_max  out  W each  extremes of the last completed window
- cal_valid  out  1  one-cycle strobe when new values are published
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky timeout flag

Function
REQ-007 Sample event: SHALL detect an event when adc_value_change differs from its registered copy; the copy updates every cycle; at most one event per cycle.
REQ-008 FSM: SHALL implement states IDLE, ACQUIRE, COMPUTE, PUBLISH.
REQ-009 IDLE: SHALL go to ACQUIRE when (start or continuous) and not abort; on entry to ACQUIRE it SHALL clear the running minimum to all-ones, running maximum to 0, sample count to 0, and timer to 0, and SHALL clear timeout_err.
REQ-010 ACQUIRE: on each event, SHALL update the running minimum and maximum with adc_value, increment the count, and zero the timer; without an event, the timer SHALL increment.
REQ-011 ACQUIRE: SHALL go to COMPUTE in the cycle after the event that brings the count to N; that Nth sample SHALL be included.
REQ-012 ACQUIRE: when the timer reaches TIMEOUT_CYCLES, SHALL go to IDLE, set timeout_err, and leave all published outputs unchanged.
REQ-013 COMPUTE: SHALL last one cycle. It SHALL compute thr = (max+min)>>1 using a W+1-bit sum with no overflow, and span = max-min. Hysteresis SHALL be HYST_MIN if span < 4*HYST_MIN, else span>>2.
REQ-014 PUBLISH: SHALL register threshold, hysteresis, win_min, and win_max, and assert cal_valid for exactly one cycle. It SHALL then go to ACQUIRE (re-initialised per REQ-009) if continuous=1, else to IDLE.
REQ-015 Latency: Nth event sampled at cycle t -> cal_valid and new values visible at cycle t+2.
REQ-016 SHALL ignore events occurring in COMPUTE, PUBLISH, or IDLE (not counted).
REQ-017 SHALL ignore start while busy=1.
REQ-018 abort=1 in ACQUIRE, COMPUTE, or PUBLISH SHALL return the FSM to IDLE next cycle with no publish and no error; abort SHALL win over the PUBLISH transition, and a PUBLISH cycle that coincides with abort SHALL not assert cal_valid. abort SHALL also win over start and continuous in IDLE.
REQ-019 Published outputs SHALL change only in PUBLISH and on reset.

Reset
REQ-020 rst SHALL put the FSM in IDLE and set: threshold = 2^(W-1), hysteresis = HYST_MIN, win_min = 0, win_max = all-ones, cal_valid = 0, busy = 0, timeout_err = 0.
REQ-021 During rst, the adc_value_change copy SHALL load the current input, so no spurious event occurs on release.
REQ-022 rst mid-window SHALL discard the partial window, with no cal_valid on the following cycle.

Verification
REQ-023 W=12, N=4, start, then samples 100,300,200,250 -> cal_valid 2 cycles after the 4th toggle; threshold=200, hysteresis=50, win_min=100, win_max=300.
REQ-024 Samples 500,505,510,502 -> span 10 < 32 -> hysteresis=8, threshold=505.
REQ-025 start, 3 samples, then no toggles for TIMEOUT_CYCLES -> IDLE, timeout_err=1, threshold remains 2048; next start clears timeout_err.
REQ-026 continuous=1, 8 samples forming two windows -> two cal_valid strobes; the second window's values are unaffected by the first window's extremes.
REQ-027 abort asserted in the COMPUTE cycle -> no cal_valid, busy=0 next cycle, outputs unchanged; start pulsed mid-ACQUIRE -> count unaffected.
REQ-028 rst asserted with adc_value_change=1 and then released -> no event counted; all outputs at REQ-020 values.
